// File: rtl/sprite_mask_streamer_if.sv
// Signal bundle between sprite_mask_streamer, the sprite-mask RAM read port
// and the frame-compositor pixel stream.
interface sprite_mask_streamer_if #(
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 8,
    parameter int COORD_W = 10
);
    logic [ADDR_W-1:0]  mem_address;
    logic               mem_chipselect;
    logic               mem_clken;
    logic [DATA_W-1:0]  mem_readdata;
    logic               pix_valid;
    logic               pix_ready;
    logic [COORD_W-1:0] pix_x;
    logic [COORD_W-1:0] pix_y;
    logic [DATA_W-1:0]  pix_data;
    logic               pix_last;

    modport master (
        output mem_address, mem_chipselect, mem_clken,
        input  mem_readdata,
        output pix_valid, pix_x, pix_y, pix_data, pix_last,
        input  pix_ready
    );

    modport slave (
        input  mem_address, mem_chipselect, mem_clken,
        output mem_readdata,
        input  pix_valid, pix_x, pix_y, pix_data, pix_last,
        output pix_ready
    );
endinterface

// File: rtl/sprite_mask_streamer.sv
// Walks a sprite mask held in on-chip RAM in raster order and streams one
// screen-space pixel beat per byte, absorbing backpressure in a 2-entry buffer.
module sprite_mask_streamer #(
    parameter int              SPR_W_LOG2       = 5,
    parameter int              SPR_H_LOG2       = 5,
    parameter int              ADDR_W           = 10,
    parameter int              DATA_W           = 8,
    parameter int              COORD_W          = 10,
    parameter logic [DATA_W-1:0] TRANSPARENT    = 8'h00,
    parameter bit              SKIP_TRANSPARENT = 1'b0
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic [COORD_W-1:0]     base_x,
    input  logic [COORD_W-1:0]     base_y,
    output logic                   busy,
    output logic                   done,
    sprite_mask_streamer_if.master bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic               last;
        logic [DATA_W-1:0]  data;
        logic [COORD_W-1:0] y;
        logic [COORD_W-1:0] x;
    } beat_t;

    localparam int                BEAT_W    = $bits(beat_t);
    localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

    state_t             state_r;
    state_t             state_s;
    logic [ADDR_W-1:0]  addr_r;
    logic               inflight_r;
    logic [ADDR_W-1:0]  inflight_addr_r;
    logic [COORD_W-1:0] base_x_r;
    logic [COORD_W-1:0] base_y_r;
    logic               busy_r;
    logic               done_r;

    beat_t              head_r;
    logic               head_valid_r;
    beat_t              spare_r;
    logic               spare_valid_r;

    logic               issue_s;
    logic               pop_s;
    logic [1:0]         occ_s;
    logic               room_s;
    logic               cap_last_s;
    logic               cap_keep_s;
    beat_t              cap_s;
    logic [1:0]         buf_next_s;

    // Occupancy bookkeeping; a beat leaving this cycle frees its slot for a new issue.
    always_comb begin
        pop_s      = head_valid_r & bus.pix_ready;
        occ_s      = {1'b0, head_valid_r} + {1'b0, spare_valid_r} + {1'b0, inflight_r};
        room_s     = ((occ_s - {1'b0, pop_s}) < 2'd2);
        buf_next_s = {1'b0, head_valid_r} + {1'b0, spare_valid_r} + {1'b0, cap_keep_s}
                     - {1'b0, pop_s};
    end

    // Build the beat for the byte arriving from RAM and decide whether it is kept.
    always_comb begin
        cap_last_s = (inflight_addr_r == LAST_ADDR);
        cap_s.last = cap_last_s;
        cap_s.data = bus.mem_readdata;
        cap_s.x    = base_x_r + COORD_W'(inflight_addr_r[SPR_W_LOG2-1:0]);
        cap_s.y    = base_y_r + COORD_W'(inflight_addr_r[SPR_W_LOG2 +: SPR_H_LOG2]);
        if (SKIP_TRANSPARENT && (bus.mem_readdata == TRANSPARENT) && !cap_last_s) begin
            cap_keep_s = 1'b0;
        end else begin
            cap_keep_s = inflight_r;
        end
    end

    // Next-state and issue decision; address 0 is issued in the accepting cycle
    // so the first beat is presented two cycles after start.
    always_comb begin
        state_s = state_r;
        issue_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    issue_s = 1'b1;
                    state_s = ST_FETCH;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_FETCH: begin
                if (room_s) begin
                    issue_s = 1'b1;
                    if (addr_r == LAST_ADDR) begin
                        state_s = ST_DRAIN;
                    end else begin
                        state_s = ST_FETCH;
                    end
                end else begin
                    state_s = ST_FETCH;
                end
            end
            ST_DRAIN: begin
                if (buf_next_s == 2'd0) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // RAM read port is driven only in issue cycles so its output register holds otherwise.
    always_comb begin
        if (issue_s) begin
            bus.mem_address    = addr_r;
            bus.mem_chipselect = 1'b1;
            bus.mem_clken      = 1'b1;
        end else begin
            bus.mem_address    = {ADDR_W{1'b0}};
            bus.mem_chipselect = 1'b0;
            bus.mem_clken      = 1'b0;
        end
    end

    // FSM state, status flags, address counter, in-flight tracking and origin latch.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r         <= ST_IDLE;
            busy_r          <= 1'b0;
            done_r          <= 1'b0;
            addr_r          <= {ADDR_W{1'b0}};
            inflight_r      <= 1'b0;
            inflight_addr_r <= {ADDR_W{1'b0}};
            base_x_r        <= {COORD_W{1'b0}};
            base_y_r        <= {COORD_W{1'b0}};
        end else begin
            state_r    <= state_s;
            busy_r     <= (state_s == ST_FETCH) || (state_s == ST_DRAIN);
            done_r     <= (state_s == ST_DONE);
            inflight_r <= issue_s;
            if (issue_s) begin
                inflight_addr_r <= addr_r;
            end
            if (state_r == ST_IDLE && start) begin
                base_x_r <= base_x;
                base_y_r <= base_y;
            end
            // The counter parks on the last address and is rearmed when the run ends.
            if (state_r == ST_DONE) begin
                addr_r <= {ADDR_W{1'b0}};
            end else if (issue_s && (addr_r != LAST_ADDR)) begin
                addr_r <= addr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
            end
        end
    end

    // Two-entry output buffer: head drives the stream, spare catches a byte during a stall.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head_r        <= beat_t'({BEAT_W{1'b0}});
            head_valid_r  <= 1'b0;
            spare_r       <= beat_t'({BEAT_W{1'b0}});
            spare_valid_r <= 1'b0;
        end else if (pop_s) begin
            if (spare_valid_r) begin
                head_r       <= spare_r;
                head_valid_r <= 1'b1;
                if (cap_keep_s) begin
                    spare_r       <= cap_s;
                    spare_valid_r <= 1'b1;
                end else begin
                    spare_valid_r <= 1'b0;
                end
            end else if (cap_keep_s) begin
                head_r       <= cap_s;
                head_valid_r <= 1'b1;
            end else begin
                head_valid_r <= 1'b0;
            end
        end else if (!head_valid_r) begin
            if (cap_keep_s) begin
                head_r       <= cap_s;
                head_valid_r <= 1'b1;
            end
        end else if (cap_keep_s) begin
            spare_r       <= cap_s;
            spare_valid_r <= 1'b1;
        end
    end

    assign busy          = busy_r;
    assign done          = done_r;
    assign bus.pix_valid = head_valid_r;
    assign bus.pix_x     = head_r.x;
    assign bus.pix_y     = head_r.y;
    assign bus.pix_data  = head_r.data;
    assign bus.pix_last  = head_r.last;

endmodule

// File: tb/tb_sprite_mask_streamer.sv
// Directed bench for sprite_mask_streamer: raster streaming, backpressure,
// coordinate wrap, transparent skipping, ignored restart and mid-stream reset.
module tb_sprite_mask_streamer;

    logic       clk;
    logic       reset_n;
    logic       start0, start1;
    logic [9:0] bx0, by0, bx1, by1;
    logic       busy0, done0, busy1, done1;

    int n_checks;
    int n_fail;

    logic [7:0] ram0 [1024];
    logic [7:0] ram1 [1024];

    sprite_mask_streamer_if #(.ADDR_W(10), .DATA_W(8), .COORD_W(10)) if0 ();
    sprite_mask_streamer_if #(.ADDR_W(10), .DATA_W(8), .COORD_W(10)) if1 ();

    sprite_mask_streamer #(.SKIP_TRANSPARENT(1'b0)) u_dut0 (
        .clk(clk), .reset_n(reset_n), .start(start0), .base_x(bx0), .base_y(by0),
        .busy(busy0), .done(done0), .bus(if0)
    );

    sprite_mask_streamer #(.SKIP_TRANSPARENT(1'b1)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .start(start1), .base_x(bx1), .base_y(by1),
        .busy(busy1), .done(done1), .bus(if1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural 1-cycle-latency RAM read ports
    always @(posedge clk) begin
        if (if0.mem_clken && if0.mem_chipselect) if0.mem_readdata <= ram0[if0.mem_address];
        if (if1.mem_clken && if1.mem_chipselect) if1.mem_readdata <= ram1[if1.mem_address];
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Expected beat {last, data, y, x} for raster index k with RAM[i] = i[7:0]
    function automatic logic [28:0] exp_beat(input logic [9:0] bx, input logic [9:0] by, input int k);
        logic [9:0] kk;
        logic [9:0] ex;
        logic [9:0] ey;
        kk = 10'(k);
        ex = bx + {5'd0, kk[4:0]};
        ey = by + {5'd0, kk[9:5]};
        return {(kk == 10'h3FF), kk[7:0], ey, ex};
    endfunction

    task automatic run_stream0(input string name, input logic [9:0] bx, input logic [9:0] by,
                               input bit rnd_ready, input int poke_beat, input int rst_beat,
                               input logic [9:0] exp_x340, input logic [9:0] exp_y340);
        int         beats, first_valid, done_cnt, done_cyc, last_acc, issued, max_out, busy_bad;
        bit         prev_stall, poked, was_reset;
        logic [29:0] prev_out, cur_out;
        logic [15:0] lfsr;
        logic [9:0]  x340, y340;
        beats = 0; first_valid = -1; done_cnt = 0; done_cyc = -1; last_acc = -1;
        issued = 0; max_out = 0; busy_bad = 0; prev_stall = 1'b0; poked = 1'b0;
        was_reset = 1'b0; prev_out = '0; lfsr = 16'hACE1; x340 = '0; y340 = '0;
        @(negedge clk);
        for (int cyc = 0; cyc < 4000; cyc++) begin
            start0 = (cyc == 0);
            if (cyc == 0) begin
                bx0 = bx;
                by0 = by;
            end
            if (!poked && poke_beat >= 0 && beats == poke_beat) begin
                start0 = 1'b1;
                bx0    = bx + 10'd7;
                by0    = by + 10'd9;
                poked  = 1'b1;
            end
            if (rnd_ready) begin
                lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
                if0.pix_ready = lfsr[0];
            end else begin
                if0.pix_ready = 1'b1;
            end
            if (rst_beat >= 0 && beats == rst_beat) begin
                reset_n = 1'b0;
                #1;
                check_eq({name, "_reset_outputs"},
                         {if0.pix_valid, if0.pix_last, if0.pix_data, if0.pix_x, if0.pix_y,
                          if0.mem_clken, if0.mem_chipselect, if0.mem_address, busy0, done0}, 64'd0);
                was_reset = 1'b1;
                break;
            end
            #1;
            if (cyc == 0)
                check_eq({name, "_first_issue"},
                         {if0.mem_clken, if0.mem_chipselect, if0.mem_address}, {1'b1, 1'b1, 10'd0});
            if (if0.mem_clken) issued++;
            cur_out = {if0.pix_valid, if0.pix_last, if0.pix_data, if0.pix_y, if0.pix_x};
            if (prev_stall) check_eq($sformatf("%s_stall_hold_c%0d", name, cyc), cur_out, prev_out);
            if (if0.pix_valid && first_valid < 0) first_valid = cyc;
            if (if0.pix_valid && if0.pix_ready) begin
                check_eq($sformatf("%s_beat%0d", name, beats), cur_out[28:0], exp_beat(bx, by, beats));
                if (beats == 340) begin
                    x340 = if0.pix_x;
                    y340 = if0.pix_y;
                end
                beats++;
                last_acc = cyc;
            end
            if (issued - beats > max_out) max_out = issued - beats;
            if (cyc >= 1) begin
                if (done0 && busy0) busy_bad++;
                if (!done0 && done_cnt == 0 && !busy0) busy_bad++;
            end
            if (done0) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            prev_stall = if0.pix_valid && !if0.pix_ready;
            prev_out   = cur_out;
            if (done_cyc >= 0 && cyc == done_cyc + 1) break;
            @(negedge clk);
        end
        start0 = 1'b0;
        if (was_reset) begin
            check_eq({name, "_beats_before_reset"}, beats, rst_beat);
            check_eq({name, "_no_done_on_abort"}, done_cnt, 0);
        end else begin
            check_eq({name, "_beat_count"}, beats, 1024);
            check_eq({name, "_first_valid_cycle"}, first_valid, 2);
            check_eq({name, "_done_pulses"}, done_cnt, 1);
            check_eq({name, "_done_after_last"}, done_cyc, last_acc + 1);
            check_eq({name, "_coord_340"}, {x340, y340}, {exp_x340, exp_y340});
            if (!rnd_ready) check_eq({name, "_last_accept_cycle"}, last_acc, 1025);
        end
        check_eq({name, "_max_outstanding_le2"}, (max_out <= 2), 1'b1);
        check_eq({name, "_busy_profile"}, busy_bad, 0);
    endtask

    task automatic run_skip1();
        int         beats, done_cnt;
        logic [28:0] got [2];
        beats = 0; done_cnt = 0;
        got[0] = '0; got[1] = '0;
        @(negedge clk);
        for (int cyc = 0; cyc < 1200; cyc++) begin
            start1 = (cyc == 0);
            bx1 = 10'd0;
            by1 = 10'd0;
            if1.pix_ready = 1'b1;
            #1;
            if (if1.pix_valid) begin
                if (beats < 2) got[beats] = {if1.pix_last, if1.pix_data, if1.pix_y, if1.pix_x};
                beats++;
            end
            if (done1) done_cnt++;
            @(negedge clk);
        end
        start1 = 1'b0;
        check_eq("skip_beat_count", beats, 2);
        check_eq("skip_beat0", got[0], {1'b0, 8'h7F, 10'd0, 10'd5});
        check_eq("skip_beat_final", got[1], {1'b1, 8'h00, 10'd31, 10'd31});
        check_eq("skip_done_pulses", done_cnt, 1);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        for (int i = 0; i < 1024; i++) begin
            ram0[i] = 8'(i);
            ram1[i] = 8'h00;
        end
        ram1[5] = 8'h7F;
        reset_n = 1'b0;
        start0 = 1'b0; start1 = 1'b0;
        bx0 = '0; by0 = '0; bx1 = '0; by1 = '0;
        if0.pix_ready = 1'b0;
        if1.pix_ready = 1'b0;
        #1;
        check_eq("reset_state_dut0",
                 {if0.pix_valid, if0.pix_last, if0.pix_data, if0.pix_x, if0.pix_y,
                  if0.mem_clken, if0.mem_chipselect, if0.mem_address, busy0, done0}, 64'd0);
        check_eq("reset_state_dut1",
                 {if1.pix_valid, if1.mem_clken, if1.mem_address, busy1, done1}, 64'd0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        run_stream0("t1_basic",   10'd100,  10'd50,   1'b0, -1, -1, 10'd120, 10'd60);
        run_stream0("t2_backpr",  10'd100,  10'd50,   1'b1, -1, -1, 10'd120, 10'd60);
        run_stream0("t3_wrap",    10'd1010, 10'd1020, 1'b0, -1, -1, 10'd6,   10'd6);
        run_skip1();
        run_stream0("t5_restart", 10'd200,  10'd300,  1'b0, 200, -1, 10'd220, 10'd310);
        run_stream0("t6_abort",   10'd100,  10'd50,   1'b0, -1, 500, 10'd0,   10'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        run_stream0("t6_after",   10'd100,  10'd50,   1'b0, -1, -1, 10'd120, 10'd60);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
